// File: rtl/pipe_stage_reg_pkg.sv
// Shared field widths, control-bundle layout and build options for the MIPS inter-stage registers.
// Build option: PIPE_FLUSH_ZERO_DATA_EN makes a flush also clear the low payload bits (PC+4 is kept).
package pipe_pkg;

   localparam int PC_W   = 32;
   localparam int REG_W  = 32;
   localparam int RIDX_W = 5;
   localparam int EX_W   = 4;
   localparam int MEM_W  = 4;
   localparam int WB_W   = 2;
   localparam int IO_W   = 1;

   // ID/EX payload, MSB first: PC+4, A, B, SignExtImm, Rt, Rd, Rs
   localparam int IDEX_DATA_W = PC_W + 3 * REG_W + 3 * RIDX_W;
   localparam int IDEX_CTRL_W = EX_W + MEM_W + WB_W + IO_W;

   localparam int CTRL_EX_LSB  = 0;
   localparam int CTRL_MEM_LSB = CTRL_EX_LSB + EX_W;
   localparam int CTRL_WB_LSB  = CTRL_MEM_LSB + MEM_W;
   localparam int CTRL_IO_BIT  = CTRL_WB_LSB + WB_W;

   localparam logic [IDEX_CTRL_W-1:0] NOP_CTRL = '0;

`ifdef PIPE_FLUSH_ZERO_DATA_EN
   localparam bit FLUSH_ZERO_DATA = 1'b1;
`else
   localparam bit FLUSH_ZERO_DATA = 1'b0;
`endif

endpackage

// File: rtl/pipe_stage_reg_slot.sv
// One pipeline entry: valid bit, control bundle and payload, with load, clear-valid and flush-zero controls.
// Under PIPE_FLUSH_ZERO_DATA_EN a flushed entry also keeps only its top KEEP_W payload bits.
module pipe_slot
   import pipe_pkg::*;
#(
   parameter int DATA_W = IDEX_DATA_W,
   parameter int CTRL_W = IDEX_CTRL_W,
   parameter int KEEP_W = PC_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              clear,
   input  logic              flush,
   input  logic [DATA_W-1:0] load_data,
   input  logic [CTRL_W-1:0] load_ctrl,
   output logic              valid,
   output logic [DATA_W-1:0] data,
   output logic [CTRL_W-1:0] ctrl
);

   // All-ones mask when the data-zeroing option is off, so the AND folds away.
   localparam logic [DATA_W-1:0] KEEP_MASK =
      FLUSH_ZERO_DATA ? {{KEEP_W{1'b1}}, {(DATA_W - KEEP_W){1'b0}}} : '1;

   // NOTE: sequential state uses non-blocking assignments so every slot samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: payload is reset as well; it is a handful of flops, not a RAM, and stays deterministic.
         valid <= 1'b0;
         data  <= '0;
         ctrl  <= '0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= flush ? (load_data & KEEP_MASK) : load_data;
         ctrl  <= flush ? '0 : load_ctrl;
      end else if (clear) begin
         valid <= 1'b0;
      end else if (flush) begin
         data <= data & KEEP_MASK;
         ctrl <= '0;
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic MIPS pipeline register with optional skid entry, flush-to-NOP and a saturating flush counter.
// Build option: PIPE_FLUSH_ZERO_DATA_EN (see pipe_slot) also clears killed operands on flush.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W = IDEX_DATA_W,
   parameter int CTRL_W = IDEX_CTRL_W,
   parameter int KEEP_W = PC_W,
   parameter int SKID   = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [15:0]       flush_cnt
);

   logic              accept;
   logic              issue;
   logic              main_valid;
   logic              main_load;
   logic              main_clear;
   logic [DATA_W-1:0] main_data;
   logic [DATA_W-1:0] main_load_data;
   logic [CTRL_W-1:0] main_ctrl;
   logic [CTRL_W-1:0] main_load_ctrl;
   logic              skid_valid;

   assign accept = in_valid & in_ready;
   assign issue  = main_valid & out_ready;

   pipe_slot #(
      .DATA_W (DATA_W),
      .CTRL_W (CTRL_W),
      .KEEP_W (KEEP_W)
   ) u_main (
      .clk       (clk),
      .reset     (reset),
      .load      (main_load),
      .clear     (main_clear),
      .flush     (flush),
      .load_data (main_load_data),
      .load_ctrl (main_load_ctrl),
      .valid     (main_valid),
      .data      (main_data),
      .ctrl      (main_ctrl)
   );

   generate
      if (SKID != 0) begin : g_skid
         logic              skid_load;
         logic              skid_clear;
         logic [DATA_W-1:0] skid_data;
         logic [CTRL_W-1:0] skid_ctrl;

         // in_ready comes straight from the skid valid flop, so stalls never form a ready chain.
         assign in_ready   = !skid_valid;
         assign skid_load  = accept & main_valid & !issue;
         assign skid_clear = skid_valid & issue;

         // FULL never accepts, so a skid refill and an upstream load cannot collide.
         assign main_load      = (accept & (!main_valid | issue)) | skid_clear;
         assign main_clear     = issue & !main_load;
         assign main_load_data = skid_valid ? skid_data : in_data;
         assign main_load_ctrl = skid_valid ? skid_ctrl : in_ctrl;

         pipe_slot #(
            .DATA_W (DATA_W),
            .CTRL_W (CTRL_W),
            .KEEP_W (KEEP_W)
         ) u_skid (
            .clk       (clk),
            .reset     (reset),
            .load      (skid_load),
            .clear     (skid_clear),
            .flush     (flush),
            .load_data (in_data),
            .load_ctrl (in_ctrl),
            .valid     (skid_valid),
            .data      (skid_data),
            .ctrl      (skid_ctrl)
         );
      end else begin : g_single
         assign skid_valid     = 1'b0;
         assign in_ready       = !main_valid | out_ready;
         assign main_load      = accept;
         assign main_clear     = issue & !accept;
         assign main_load_data = in_data;
         assign main_load_ctrl = in_ctrl;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         flush_cnt <= '0;
      end else if (flush && (main_valid || skid_valid || accept) && (flush_cnt != 16'hFFFF)) begin
         flush_cnt <= flush_cnt + 16'd1;
      end
   end

   assign out_valid = main_valid;
   assign out_data  = main_data;
   assign out_ctrl  = main_valid ? main_ctrl : CTRL_W'(NOP_CTRL);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: skid build (dut) and single-entry build (dut0) side by side.
module tb_pipe_stage_reg;
   import pipe_pkg::*;

   localparam int DW = 143;
   localparam int CW = 11;

   logic          clk = 1'b0;
   logic          reset;

   logic          in_valid, in_ready, flush, out_valid, out_ready;
   logic [DW-1:0] in_data, out_data;
   logic [CW-1:0] in_ctrl, out_ctrl;
   logic [15:0]   flush_cnt;

   logic          s_in_valid, s_in_ready, s_flush, s_out_valid, s_out_ready;
   logic [DW-1:0] s_in_data, s_out_data;
   logic [CW-1:0] s_in_ctrl, s_out_ctrl;
   logic [15:0]   s_flush_cnt;

   logic [DW-1:0] d0, d1, d2, d3, d4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .KEEP_W(32), .SKID(1)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
      .flush_cnt(flush_cnt)
   );

   pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .KEEP_W(32), .SKID(0)) dut0 (
      .clk(clk), .reset(reset),
      .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data), .in_ctrl(s_in_ctrl),
      .flush(s_flush),
      .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data), .out_ctrl(s_out_ctrl),
      .flush_cnt(s_flush_cnt)
   );

   task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DW-1:0] flushed(input logic [DW-1:0] d);
`ifdef PIPE_FLUSH_ZERO_DATA_EN
      return {d[DW-1:DW-32], {(DW-32){1'b0}}};
`else
      return d;
`endif
   endfunction

   initial begin
      d0 = {32'h0040_0004, 111'h1234_5678_9ABC};
      d1 = {32'h0040_0008, 111'h7_0000_0000_0000_0001_FFFF};
      d2 = {32'h0040_000C, 111'h55_AAAA};
      d3 = {32'h0040_0010, 111'hF_0F0F_0F0F};
      d4 = {32'h0040_0014, 111'h1};

      // Reset with live inputs: they must be ignored.
      reset = 1'b1;
      in_valid = 1'b1; in_data = d0; in_ctrl = 11'h7FF; flush = 1'b0; out_ready = 1'b0;
      s_in_valid = 1'b0; s_in_data = '0; s_in_ctrl = '0; s_flush = 1'b0; s_out_ready = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      in_valid = 1'b0;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_ctrl", out_ctrl, 11'h000);
      check("rst_out_data", out_data, '0);
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_flush_cnt", flush_cnt, 16'h0000);
      check("rst_s_out_valid", s_out_valid, 1'b0);

      // Streaming at full rate.
      out_ready = 1'b1; in_valid = 1'b1; in_ctrl = 11'h7FF;
      for (int i = 0; i < 8; i++) begin
         in_data = DW'(i);
         tick();
         check("stream_valid", out_valid, 1'b1);
         check("stream_data", out_data, DW'(i));
         check("stream_ctrl", out_ctrl, 11'h7FF);
         check("stream_in_ready", in_ready, 1'b1);
      end
      in_valid = 1'b0;
      tick();
      check("drain_valid", out_valid, 1'b0);
      check("drain_ctrl_gated", out_ctrl, 11'h000);

      // Stall into skid, then release.
      out_ready = 1'b0; in_valid = 1'b1; in_data = DW'(8'hA0);
      tick();
      check("stall_one_data", out_data, DW'(8'hA0));
      check("stall_one_in_ready", in_ready, 1'b1);
      in_data = DW'(8'hA1);
      tick();
      check("stall_full_in_ready", in_ready, 1'b0);
      check("stall_full_data", out_data, DW'(8'hA0));
      in_valid = 1'b0; out_ready = 1'b1;
      tick();
      check("release_d1_data", out_data, DW'(8'hA1));
      check("release_d1_valid", out_valid, 1'b1);
      check("release_in_ready", in_ready, 1'b1);
      tick();
      check("release_empty", out_valid, 1'b0);

      // Flush while FULL.
      out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 11'h7FF; in_data = d0;
      tick();
      in_data = d1;
      tick();
      in_valid = 1'b0; flush = 1'b1;
      tick();
      flush = 1'b0;
      check("fullflush_valid", out_valid, 1'b1);
      check("fullflush_ctrl", out_ctrl, 11'h000);
      check("fullflush_data", out_data, flushed(d0));
      check("fullflush_in_ready", in_ready, 1'b0);
      check("fullflush_cnt", flush_cnt, 16'h0001);
      out_ready = 1'b1;
      tick();
      check("fullflush_skid_valid", out_valid, 1'b1);
      check("fullflush_skid_ctrl", out_ctrl, 11'h000);
      check("fullflush_skid_data", out_data, flushed(d1));
      tick();
      check("fullflush_empty", out_valid, 1'b0);

      // Flush + issue + accept in state ONE.
      in_valid = 1'b1; in_data = d2; in_ctrl = 11'h7FF;
      tick();
      in_data = d3; flush = 1'b1;
      #1;
      check("fia_depart_ctrl", out_ctrl, 11'h7FF);
      check("fia_depart_data", out_data, d2);
      tick();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      check("fia_new_valid", out_valid, 1'b1);
      check("fia_new_ctrl", out_ctrl, 11'h000);
      check("fia_new_data", out_data, flushed(d3));
      check("fia_cnt", flush_cnt, 16'h0002);

      // Reset from FULL.
      in_valid = 1'b1; in_data = d4; in_ctrl = 11'h7FF;
      tick();
      check("prerst_full", in_ready, 1'b0);
      reset = 1'b1;
      tick();
      reset = 1'b0; in_valid = 1'b0;
      check("midrst_valid", out_valid, 1'b0);
      check("midrst_ctrl", out_ctrl, 11'h000);
      check("midrst_in_ready", in_ready, 1'b1);
      check("midrst_cnt", flush_cnt, 16'h0000);

      // Counter saturation.
      in_valid = 1'b1; in_data = d0;
      tick();
      in_valid = 1'b0; flush = 1'b1;
      repeat (65534) tick();
      check("sat_fffe", flush_cnt, 16'hFFFE);
      tick();
      check("sat_ffff", flush_cnt, 16'hFFFF);
      tick();
      check("sat_hold", flush_cnt, 16'hFFFF);
      flush = 1'b0;

      // Single-entry build.
      s_in_valid = 1'b1; s_in_data = DW'(8'h11); s_in_ctrl = 11'h155; s_out_ready = 1'b0;
      #1;
      check("s_empty_in_ready", s_in_ready, 1'b1);
      tick();
      check("s_load_valid", s_out_valid, 1'b1);
      check("s_load_data", s_out_data, DW'(8'h11));
      check("s_load_ctrl", s_out_ctrl, 11'h155);
      check("s_stall_in_ready", s_in_ready, 1'b0);
      s_out_ready = 1'b1; s_in_data = DW'(8'h22);
      #1;
      check("s_comb_in_ready", s_in_ready, 1'b1);
      tick();
      check("s_pass_valid", s_out_valid, 1'b1);
      check("s_pass_data", s_out_data, DW'(8'h22));
      s_in_valid = 1'b0;
      tick();
      check("s_drain_valid", s_out_valid, 1'b0);
      check("s_drain_ctrl", s_out_ctrl, 11'h000);
      s_in_valid = 1'b1; s_in_data = d3; s_out_ready = 1'b0;
      tick();
      s_in_valid = 1'b0; s_flush = 1'b1;
      tick();
      s_flush = 1'b0;
      check("s_flush_valid", s_out_valid, 1'b1);
      check("s_flush_ctrl", s_out_ctrl, 11'h000);
      check("s_flush_data", s_out_data, flushed(d3));
      check("s_flush_cnt", s_flush_cnt, 16'h0001);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
